// File: rtl/proc_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : proc_ctrl_seq_if
// Purpose  : Bundle carrying the sequencer's handshake and control signals
//            between the control sequencer and the processor datapath.
// Signals  : run, din[8:0], g_nz         -> into the sequencer
//            sel[9:0], r_in[7:0], a_in,
//            g_in, ir_in, add_sub, done  <- out of the sequencer
// Modports : master - the control sequencer (drives bus select / enables)
//            slave  - the datapath side (drives run/din/g_nz, consumes rest)
// Revision : 1.0 - initial release
// ============================================================================
interface proc_ctrl_seq_if;
  logic       run;
  logic [8:0] din;
  logic       g_nz;
  logic [9:0] sel;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       ir_in;
  logic       add_sub;
  logic       done;

  modport master (
    input  run, din, g_nz,
    output sel, r_in, a_in, g_in, ir_in, add_sub, done
  );

  modport slave (
    output run, din, g_nz,
    input  sel, r_in, a_in, g_in, ir_in, add_sub, done
  );
endinterface
`default_nettype wire

// File: rtl/proc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : proc_ctrl_seq
// Purpose  : Control sequencer for the simple processor datapath. Fetches a
//            9-bit instruction {op, x, y} in T0 and steps through T1..T3,
//            issuing the one-hot bus select, register/A/G load enables, the
//            ALU add/subtract control and a one-cycle done strobe.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-high reset
//            bus    - proc_ctrl_seq_if.master (run, din, g_nz in;
//                     sel, r_in, a_in, g_in, ir_in, add_sub, done out)
// Config   : PROC_CTRL_MVNZ_EN - when defined, opcode 100 is MVNZ (move
//            R[y] to R[x] only if g_nz); otherwise opcode 100 is a NOP and
//            g_nz is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module proc_ctrl_seq (
  input  wire               clk,
  input  wire               reset,
  proc_ctrl_seq_if.master   bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] c_op_mv   = 3'b000;
  localparam logic [2:0] c_op_mvi  = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_sub  = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
  localparam logic [2:0] c_op_mvnz = 3'b100;
`endif

  localparam logic [9:0] c_sel_din = 10'b0000000001;
  localparam logic [9:0] c_sel_g   = 10'b1000000000;

  state_t     r_state;
  logic [8:0] r_ir;

  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;

  logic [9:0] w_sel;
  logic [7:0] w_r_in;
  logic       w_a_in;
  logic       w_g_in;
  logic       w_ir_in;
  logic       w_add_sub;
  logic       w_done;

  assign w_op = r_ir[8:6];
  assign w_x  = r_ir[5:3];
  assign w_y  = r_ir[2:0];

  // Register k sits on bus select bit k+1 (bit 0 is DIN).
  function automatic logic [9:0] reg_sel(input logic [2:0] k);
    reg_sel = 10'b0000000010 << k;
  endfunction

  function automatic logic [7:0] reg_load(input logic [2:0] k);
    reg_load = 8'b00000001 << k;
  endfunction

  // --------------------------------------------------------------------------
  // State register and instruction register. IR is only written on the
  // fetch edge, so it stays stable for the whole of T1..T3.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= T0;
      r_ir    <= 9'b0;
    end else begin
      case (r_state)
        T0: begin
          if (bus.run) begin
            r_ir    <= bus.din;
            r_state <= T1;
          end
        end
        T1: begin
          if (w_op == c_op_add || w_op == c_op_sub) begin
            r_state <= T2;
          end else begin
            r_state <= T0;
          end
        end
        T2:      r_state <= T3;
        T3:      r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Combinational from state and IR so the datapath sees the
  // controls in the same cycle the state is entered.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel     = c_sel_din;
    w_r_in    = 8'b0;
    w_a_in    = 1'b0;
    w_g_in    = 1'b0;
    w_ir_in   = 1'b0;
    w_add_sub = 1'b0;
    w_done    = 1'b0;

    case (r_state)
      T0: begin
        // Reset gates the fetch strobe so nothing is captured while held.
        w_ir_in = bus.run & ~reset;
      end
      T1: begin
        case (w_op)
          c_op_mv: begin
            w_sel  = reg_sel(w_y);
            w_r_in = reg_load(w_x);
            w_done = 1'b1;
          end
          c_op_mvi: begin
            w_sel  = c_sel_din;
            w_r_in = reg_load(w_x);
            w_done = 1'b1;
          end
          c_op_add, c_op_sub: begin
            w_sel  = reg_sel(w_x);
            w_a_in = 1'b1;
          end
`ifdef PROC_CTRL_MVNZ_EN
          c_op_mvnz: begin
            w_sel  = reg_sel(w_y);
            w_r_in = bus.g_nz ? reg_load(w_x) : 8'b0;
            w_done = 1'b1;
          end
`endif
          default: begin
            // Unassigned opcodes retire as a NOP in a single execute cycle.
            w_done = 1'b1;
          end
        endcase
      end
      T2: begin
        w_sel     = reg_sel(w_y);
        w_g_in    = 1'b1;
        w_add_sub = (w_op == c_op_sub);
      end
      T3: begin
        w_sel  = c_sel_g;
        w_r_in = reg_load(w_x);
        w_done = 1'b1;
      end
      default: begin
        w_sel = c_sel_din;
      end
    endcase
  end

`ifndef PROC_CTRL_MVNZ_EN
  // g_nz has no consumer when MVNZ is compiled out.
  logic w_unused;
  assign w_unused = bus.g_nz;
`endif

  assign bus.sel     = w_sel;
  assign bus.r_in    = w_r_in;
  assign bus.a_in    = w_a_in;
  assign bus.g_in    = w_g_in;
  assign bus.ir_in   = w_ir_in;
  assign bus.add_sub = w_add_sub;
  assign bus.done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_ctrl_seq
// Purpose  : Directed self-checking bench for proc_ctrl_seq. Each scenario
//            task drives an instruction and compares the full output vector
//            {sel, r_in, a_in, g_in, ir_in, add_sub, done} in every cycle
//            against hand-computed values.
// Config   : PROC_CTRL_MVNZ_EN selects the expected MVNZ behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_ctrl_seq;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  proc_ctrl_seq_if bus_if ();

  proc_ctrl_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: sel[22:13] r_in[12:5] a_in g_in ir_in add_sub done
  function automatic logic [22:0] obs();
    return {bus_if.sel, bus_if.r_in, bus_if.a_in, bus_if.g_in,
            bus_if.ir_in, bus_if.add_sub, bus_if.done};
  endfunction

  function automatic logic [22:0] ev(input logic [9:0] s, input logic [7:0] r,
                                     input logic a, input logic g,
                                     input logic ir, input logic as,
                                     input logic d);
    return {s, r, a, g, ir, as, d};
  endfunction

  localparam logic [22:0] DEF = {10'b0000000001, 8'b0, 5'b0};

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    reset = 1'b1;
    bus_if.run = 1'b1;
    bus_if.din = 9'b001000000;
    bus_if.g_nz = 1'b0;
    wait_edge();
    wait_edge();
    e = DEF;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", obs(), e);
    end
    n_tests++;
    bus_if.run = 1'b0;
    reset = 1'b0;
    wait_edge();
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL idle_t0: got %b expected %b", obs(), e);
    end
    n_tests++;
  endtask

  task automatic test_mvi();
    logic [22:0] e;
    bus_if.din = 9'b001000000;
    bus_if.run = 1'b1;
    #1;
    e = ev(10'b0000000001, 8'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL mvi_fetch: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
    bus_if.run = 1'b0;
    #1;
    e = ev(10'b0000000001, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL mvi_t1: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
    if (obs() !== DEF) begin
      n_fail++;
      $display("FAIL mvi_back_t0: got %b expected %b", obs(), DEF);
    end
    n_tests++;
  endtask

  task automatic test_mv();
    logic [22:0] e;
    bus_if.din = 9'b000011000;
    bus_if.run = 1'b1;
    wait_edge();
    bus_if.run = 1'b0;
    #1;
    e = ev(10'b0000000010, 8'b00001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL mv_t1: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
  endtask

  // ALU instruction: checks T1, T2, T3 then the return to T0.
  task automatic test_alu(input logic [8:0] instr, input logic [9:0] s1,
                          input logic [9:0] s2, input logic as,
                          input logic [7:0] rl);
    logic [22:0] e;
    bus_if.din = instr;
    bus_if.run = 1'b1;
    wait_edge();
    bus_if.run = 1'b0;
    #1;
    e = ev(s1, 8'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL alu_t1 %b: got %b expected %b", instr, obs(), e);
    end
    n_tests++;
    wait_edge();
    e = ev(s2, 8'b0, 1'b0, 1'b1, 1'b0, as, 1'b0);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL alu_t2 %b: got %b expected %b", instr, obs(), e);
    end
    n_tests++;
    wait_edge();
    e = ev(10'b1000000000, rl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL alu_t3 %b: got %b expected %b", instr, obs(), e);
    end
    n_tests++;
    wait_edge();
    if (obs() !== DEF) begin
      n_fail++;
      $display("FAIL alu_end %b: got %b expected %b", instr, obs(), DEF);
    end
    n_tests++;
  endtask

  task automatic test_reset_abort();
    logic [22:0] e;
    bus_if.din = 9'b011010010;  // SUB R2,R2
    bus_if.run = 1'b1;
    wait_edge();
    bus_if.run = 1'b0;
    wait_edge();
    e = ev(10'b0000001000, 8'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL abort_t2: got %b expected %b", obs(), e);
    end
    n_tests++;
    reset = 1'b1;
    bus_if.run = 1'b1;
    #1;
    if (obs() !== DEF) begin
      n_fail++;
      $display("FAIL abort_async: got %b expected %b", obs(), DEF);
    end
    n_tests++;
    #1;
    bus_if.run = 1'b0;
    reset = 1'b0;
    wait_edge();
    if (obs() !== DEF) begin
      n_fail++;
      $display("FAIL abort_no_t3: got %b expected %b", obs(), DEF);
    end
    n_tests++;
    bus_if.din = 9'b001110000;  // MVI R6
    bus_if.run = 1'b1;
    wait_edge();
    bus_if.run = 1'b0;
    #1;
    e = ev(10'b0000000001, 8'b01000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL abort_restart: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
  endtask

  task automatic test_mvnz();
    logic [22:0] e;
    for (int i = 0; i < 2; i++) begin
      bus_if.g_nz = (i == 0);
      bus_if.din = 9'b100101110;  // MVNZ R5,R6
      bus_if.run = 1'b1;
      wait_edge();
      bus_if.run = 1'b0;
      #1;
`ifdef PROC_CTRL_MVNZ_EN
      e = ev(10'b0010000000, (i == 0) ? 8'b00100000 : 8'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
      e = ev(10'b0000000001, 8'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL mvnz_gnz%0d: got %b expected %b", 1 - i, obs(), e);
      end
      n_tests++;
      wait_edge();
    end
    bus_if.g_nz = 1'b0;
  endtask

  // Unused opcodes retire as NOP; run held high in T1 must not refetch.
  task automatic test_nop();
    logic [22:0] e;
    logic [2:0]  ops [3] = '{3'b111, 3'b101, 3'b110};
    for (int i = 0; i < 3; i++) begin
      bus_if.din = {ops[i], 6'b011101};
      bus_if.run = 1'b1;
      wait_edge();
      bus_if.din = 9'b001000000;
      #1;
      e = ev(10'b0000000001, 8'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL nop_op%b: got %b expected %b", ops[i], obs(), e);
      end
      n_tests++;
      bus_if.run = 1'b0;
      wait_edge();
    end
  endtask

  // run held high and din changing during T1..T3 must not disturb the
  // ADD R4,R7; then the next instruction starts with no gap cycle.
  task automatic test_back_to_back();
    logic [22:0] e;
    bus_if.din = 9'b010100111;
    bus_if.run = 1'b1;
    wait_edge();
    bus_if.din = 9'b000000001;
    #1;
    e = ev(10'b0000100000, 8'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL b2b_t1: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
    bus_if.din = 9'b011001010;
    #1;
    e = ev(10'b0100000000, 8'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL b2b_t2: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
    bus_if.din = 9'b000001010;  // next: MV R1,R2
    #1;
    e = ev(10'b1000000000, 8'b00010000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL b2b_t3: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
    e = ev(10'b0000000001, 8'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL b2b_fetch: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
    bus_if.run = 1'b0;
    #1;
    e = ev(10'b0000001000, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL b2b_mv: got %b expected %b", obs(), e);
    end
    n_tests++;
    wait_edge();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_mvi();
    test_mv();
    // ADD R1,R2
    test_alu(9'b010001010, 10'b0000000100, 10'b0000001000, 1'b0, 8'b00000010);
    // SUB R1,R2
    test_alu(9'b011001010, 10'b0000000100, 10'b0000001000, 1'b1, 8'b00000010);
    // SUB R7,R4
    test_alu(9'b011111100, 10'b0100000000, 10'b0000100000, 1'b1, 8'b10000000);
    // ADD R2,R2
    test_alu(9'b010010010, 10'b0000001000, 10'b0000001000, 1'b0, 8'b00000100);
    test_reset_abort();
    test_mvnz();
    test_nop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
